fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end with a small prefetch buffer. It owns the fetch PC and issues sequential word fetches to instruction memory over a request/response handshake. Returned instructions are queued together with their PC+4 and presented to the IF/ID register. The queue absorbs memory latency and downstream freeze, and a taken branch flushes it and redirects the fetch PC.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, minimum 2.
- `RESET_PC`, default 32'h0: fetch PC after reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `freeze` in 1: downstream stall; the head entry is held while high.
- `branch_taken` in 1: redirect request, single-cycle pulse.
- `branch_addr` in `WORD_WIDTH`: redirect target, word aligned.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out `WORD_WIDTH`: fetch address; equals the fetch PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid, in order, with at most one outstanding.
- `imem_rdata` in `WORD_WIDTH`: fetched instruction word.
- `valid` out 1: the head entry is presented.
- `pc` out `WORD_WIDTH`: PC+4 of the presented instruction; 0 when `valid`=0.
- `instruction` out `WORD_WIDTH`: presented instruction; 0 (NOP) when `valid`=0.

## Operation
**State**
- `fetch_pc` register.
- `outstanding` flag.
- `discard` flag.
- Queue storage, `rd_ptr`, `wr_ptr`, and `count` (0..DEPTH).

**Issue**
- `imem_req` = !`branch_taken` && !`outstanding` && (`count` < DEPTH).
- The slot for the response is reserved at issue, so the queue never overflows.

**Accept**
- Accept occurs when `imem_req` && `imem_ready`.
- On accept: `outstanding` is set and `fetch_pc` advances by 4.
- `fetch_pc` wraps modulo 2^32.

**Response**
- `imem_rvalid` with `outstanding`=1 clears `outstanding`.
- If `discard`=0, the entry {`fetch_pc_of_request`+4, `imem_rdata`} is pushed.
- If `discard`=1, the response is dropped and `discard` is cleared.
- `imem_rvalid` with `outstanding`=0 is ignored.

**Pop**
- A pop occurs when `valid` && !`freeze`.
- `rd_ptr` increments, wrapping modulo DEPTH.
- If push and pop happen in the same cycle, `count` is unchanged.

**Branch**
- When `branch_taken` is high at an edge:
  - `fetch_pc` is set to `branch_addr`.
  - `count`, `rd_ptr` and `wr_ptr` are set to 0.
  - `discard` is set if a request is outstanding and its response has not arrived in this same cycle.
- Any same-cycle push or pop is cancelled.
- `branch_taken` overrides `freeze`.

**Reset**
- All outputs are 0 while reset is asserted.
- `fetch_pc` is set to `RESET_PC`.
- `count`, the pointers, `outstanding` and `discard` are set to 0.
- Assertion mid-transaction abandons the in-flight request. Its late response arrives with `outstanding`=0 and is ignored.

## Timing
- `imem_req` is combinational from registered state and `branch_taken`. There is no other combinational input-to-output path, except with the bypass described under Configuration.
- Request accepted in cycle t with a response in cycle t+k: `valid` rises in cycle t+k+1.
- With `imem_ready`=1 and a 1-cycle memory, one fetch is issued every 2 cycles.
- Full queue (`count`=DEPTH): `imem_req`=0 until a pop. A pop in cycle t allows an issue in cycle t+1.
- Empty queue: `valid`=0, and `freeze` has no effect.
- Branch at edge e: the new target is requested in the first cycle after e that has no outstanding request. `valid`=0 from e until the target's response is queued.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count`=0 and an undiscarded response arrives, `valid`, `pc` and `instruction` reflect the response combinationally in the same cycle.
  - If `freeze`=0 in that cycle, the entry is consumed and not pushed.
  - If `freeze`=1, the entry is pushed normally.
  - Latency from accept to `valid` becomes k cycles.
  - A branch in the same cycle still cancels the bypass: `valid`=0.
- Not defined: no bypass; all responses pass through the queue, with latency as stated under Timing.

## Test plan
- **Reset:** `RESET_PC`=0, memory with 1-cycle latency, `freeze`=0, release reset. Required: `imem_addr` sequence 0, 4, 8. Outputs `pc`=4, 8, 12 with matching words, with `valid` high every other cycle.
- **Full queue:** hold `freeze`=1 for 12 cycles. Required:
  - `count` reaches DEPTH=4 and `imem_req` stays 0.
  - After `freeze` drops, 4 consecutive valid pops occur in order.
  - A new request is issued the cycle after the first pop.
- **Branch with an outstanding request:** assert `branch_taken` with `branch_addr`=32'h100 while a request to 32'h10 is outstanding. Required:
  - The 32'h10 response is dropped.
  - The next request is to 32'h100.
  - The first valid output has `pc`=32'h104.
- **Branch during freeze:** `freeze`=1, queue holds 3 entries, `branch_taken` pulses. Required: `valid`=0 the next cycle and `count`=0.
- **Reset mid-operation:** assert `rst` low during an outstanding request, then release. Required:
  - All outputs are 0 during reset.
  - The late `imem_rvalid` is ignored.
  - Fetching restarts at `RESET_PC`.
- **PC wrap:** start at 32'hFFFF_FFFC. Required: the next `imem_addr` is 0 and the delivered `pc` is 0 for the wrapped fetch.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction fetch front end with a small prefetch buffer. Owns the fetch PC,
// issues sequential word fetches over a request/response handshake (at most one
// outstanding), queues each returned word with its PC+4, and presents the head
// entry to the IF/ID register. A taken branch flushes the queue and redirects
// the fetch PC. A response to a request that was in flight at the branch is
// dropped.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present an undiscarded
// response combinationally when the queue is empty. It is consumed directly if
// freeze is low, and pushed normally if freeze is high.
//
// Parameters:
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  fetch PC after reset
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   freeze        in   downstream stall; head entry held while high
//   branch_taken  in   redirect pulse; flushes queue, overrides freeze
//   branch_addr   in   redirect target (word aligned)
//   imem_req      out  fetch request valid
//   imem_addr     out  fetch address (the fetch PC)
//   imem_ready    in   memory accepts the request this cycle
//   imem_rvalid   in   response valid (in order)
//   imem_rdata    in   fetched instruction word
//   valid         out  head entry presented
//   pc            out  PC+4 of the presented instruction, 0 when not valid
//   instruction   out  presented instruction, 0 (NOP) when not valid
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instruction
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      r_fetch_pc;
    logic             r_outstanding;
    logic             r_discard;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];

    logic w_nonempty;
    logic w_resp;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_bypass;

    assign w_nonempty = (r_count != '0);
    assign w_resp     = imem_rvalid && r_outstanding;

    // Only one request may be in flight and its slot must be free, so the
    // queue can never overflow. The rst term keeps every output at 0 while
    // reset is held.
    assign imem_req  = rst && !branch_taken && !r_outstanding && (r_count < FULL);
    assign imem_addr = rst ? r_fetch_pc : '0;
    assign w_accept  = imem_req && imem_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_resp && !r_discard && !branch_taken && !w_nonempty;
    // A bypassed entry that is consumed in the same cycle never enters storage.
    assign w_push   = w_resp && !r_discard && !branch_taken && !(w_bypass && !freeze);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_resp && !r_discard && !branch_taken;
`endif

    assign w_pop = w_nonempty && !freeze && !branch_taken;
    assign valid = w_nonempty || w_bypass;

    always_comb begin
        pc          = '0;
        instruction = '0;
        if (w_nonempty) begin
            pc          = r_mem_pc[r_rd_ptr];
            instruction = r_mem_instr[r_rd_ptr];
        end else if (w_bypass) begin
            pc          = r_fetch_pc;
            instruction = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (branch_taken) begin
            r_fetch_pc    <= branch_addr;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            // A request still in flight must have its response dropped.
            r_outstanding <= r_outstanding && !w_resp;
            r_discard     <= r_outstanding && !w_resp;
        end else begin
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            if (w_resp && r_discard) begin
                r_discard <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // With one request in flight the fetch PC has already advanced past it,
    // so r_fetch_pc is exactly the PC+4 of the returning word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
